barrel_normalizer_seq: RTL and testbench
========================================

Name: barrel_normalizer_seq

Overview:
Iterative normalizer that recovers the shift amount a logical barrel shift applies. It shifts a captured word one bit per cycle until the leading 1 reaches the MSB (dir=0) or the trailing 1 reaches the LSB (dir=1). It reports the normalized word and the number of positions shifted. It sits beside barrel_shifter_logical in the datapath and feeds sh_amt/dir back to it for re-alignment.

Parameters:
N, 8, data width in bits (power of 2, >=2)
SW, $clog2(N), width of the shift-amount output

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
din  input  N  word to normalize, captured with start
dir  input  1  0 = normalize left (count leading zeros), 1 = normalize right (count trailing zeros); captured with start
busy  output  1  high from the edge after start is accepted until the edge done asserts
done  output  1  one-cycle pulse, result valid
dout  output  N  normalized word, held until the next done
sh_amt  output  SW  positions shifted, held until the next done
zero  output  1  din was all zeros, held until the next done

Behaviour:
- Reset: on any rising edge with rst=1, state=IDLE and busy, done, dout, sh_amt, zero and internal regs all go to 0. Reset has priority over everything, including mid-SHIFT; the in-flight operation is discarded with no done.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - If start=1 at edge k: sreg<=din, cnt<=0, dreg<=dir, busy<=1, state<=SHIFT.
  - done is 0 in every cycle except the pulse cycle.
- SHIFT (one evaluation per edge):
  - If sreg==0: zero<=1, dout<=0, sh_amt<=0, done<=1, busy<=0, state<=IDLE.
  - Else if the target bit is 1 (sreg[N-1] for dreg=0, sreg[0] for dreg=1): dout<=sreg, sh_amt<=cnt, zero<=0, done<=1, busy<=0, state<=IDLE.
  - Otherwise: sreg<=sreg<<1 (dreg=0) or sreg>>1 (dreg=1), zero-filled; cnt<=cnt+1.
- Latency: done is high in the cycle after edge k+1+c, where c is the final count. That is 2 edges for c=0 and for din=0. The maximum is N+1 edges (c=N-1).
- cnt never exceeds N-1, so SW bits suffice and no wrap is possible.
- start while busy=1 is ignored: no queueing, no effect on the in-flight operation.
- start in the same cycle as the done pulse: state is still SHIFT, so it is ignored. A new start is accepted from the first IDLE cycle.
- Outputs change only at a done edge or at reset. They are stable and readable whenever busy=0.
- Invariant for din!=0:
  - dir=0: dout == din << sh_amt and dout[N-1]=1.
  - dir=1: dout == din >> sh_amt and dout[0]=1.

Decomposition:
- Shared package barrel_pkg: state encoding (ST_IDLE=1'b0, ST_SHIFT=1'b1) and direction constants (DIR_LEFT=1'b0, DIR_RIGHT=1'b1).
- barrel_shifter_logical must use the same direction constants.
- No sub-module: a single FSM plus a shift register and a counter. The natural size is 120-200 lines.

Test Plan (N=8):
1. dir=0, din=10110011, start pulse -> done 2 edges later, dout=10110011, sh_amt=000, zero=0, busy high for exactly 1 cycle.
2. dir=0, din=00010110 -> done after 5 edges, dout=10110000, sh_amt=011. Feeding dout back through barrel_shifter_logical with dir=1, sh_amt=3 returns 00010110.
3. dir=1, din=10110000 -> dout=00001011, sh_amt=100, zero=0.
4. din=00000000 (either dir) -> done after 2 edges, zero=1, dout=0, sh_amt=0. A following din=10000000, dir=0 clears zero to 0.
5. dir=0, din=00000001 -> sh_amt=111, dout=10000000, done after 9 edges. A second start with din=11111111 issued at cycle 3 is ignored and the results are unchanged.
6. dir=0, din=00000100, rst=1 asserted 3 cycles after start -> next cycle busy=0, done=0, dout=0, sh_amt=0, zero=0, and no done ever follows. A new start with din=01000000 then gives sh_amt=001.

Source files
------------

// File: rtl/barrel_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
// Shared encodings for the barrel shifter / normalizer datapath.
//   state_e : normalizer FSM states (IDLE, SHIFT)
//   DIR_*   : shift direction, common to barrel_shifter_logical and
//             barrel_normalizer_seq so sh_amt/dir can be fed straight back.
// -----------------------------------------------------------------------------
package barrel_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;  // normalize toward MSB (leading zeros)
    localparam logic DIR_RIGHT = 1'b1;  // normalize toward LSB (trailing zeros)

endpackage

// File: rtl/barrel_normalizer_seq_if.sv
// -----------------------------------------------------------------------------
// barrel_normalizer_seq_if
// Request/result bundle of the iterative normalizer.
//   start, din, dir              : request (master -> slave)
//   busy, done, dout, sh_amt, zero : status/result (slave -> master)
// Modports: master (requester), slave (normalizer).
// -----------------------------------------------------------------------------
interface barrel_normalizer_seq_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic          start;
    logic [N-1:0]  din;
    logic          dir;
    logic          busy;
    logic          done;
    logic [N-1:0]  dout;
    logic [SW-1:0] sh_amt;
    logic          zero;

    modport master (
        output start, din, dir,
        input  busy, done, dout, sh_amt, zero
    );

    modport slave (
        input  start, din, dir,
        output busy, done, dout, sh_amt, zero
    );
endinterface

// File: rtl/barrel_normalizer_seq.sv
// -----------------------------------------------------------------------------
// barrel_normalizer_seq
// Iterative normalizer: shifts a captured word one bit per cycle until the
// leading 1 reaches the MSB (dir=0) or the trailing 1 reaches the LSB (dir=1),
// then reports the normalized word and the number of positions shifted.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (discards any in-flight operation)
//   bus  : slave side of barrel_normalizer_seq_if
//          start/din/dir in; busy, done (1-cycle pulse), dout, sh_amt, zero out
// Results are held until the next done and are readable whenever busy=0.
// -----------------------------------------------------------------------------
module barrel_normalizer_seq
    import barrel_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    barrel_normalizer_seq_if.slave   bus
);

    state_e        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          dreg_q, dreg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  dout_q, dout_d;
    logic [SW-1:0] sh_q, sh_d;
    logic          zero_q, zero_d;

    // Bit that must be 1 for the word to count as normalized.
    logic tgt_bit;
    assign tgt_bit = (dreg_q == DIR_LEFT) ? sreg_q[N-1] : sreg_q[0];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dreg_d  = dreg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        sh_d    = sh_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sreg_d  = bus.din;
                    cnt_d   = '0;
                    dreg_d  = bus.dir;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // start is not looked at here: requests while busy are dropped.
                if (sreg_q == '0) begin
                    zero_d  = 1'b1;
                    dout_d  = '0;
                    sh_d    = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tgt_bit) begin
                    dout_d  = sreg_q;
                    sh_d    = cnt_q;
                    zero_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    // A nonzero word reaches its target within N-1 shifts,
                    // so cnt cannot wrap.
                    sreg_d = (dreg_q == DIR_LEFT) ? (sreg_q << 1) : (sreg_q >> 1);
                    cnt_d  = cnt_q + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dreg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            sh_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dreg_q  <= dreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            sh_q    <= sh_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.dout   = dout_q;
    assign bus.sh_amt = sh_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_barrel_normalizer_seq.sv
// -----------------------------------------------------------------------------
// tb_barrel_normalizer_seq
// Directed bench for barrel_normalizer_seq (N=8) with hand-computed results.
// -----------------------------------------------------------------------------
module tb_barrel_normalizer_seq;
    localparam int N  = 8;
    localparam int SW = 3;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    barrel_normalizer_seq_if #(.N(N), .SW(SW)) bif ();

    barrel_normalizer_seq #(.N(N), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; it is sampled at the edge between the two negedges.
    task automatic launch(input logic [N-1:0] d, input logic r);
        @(negedge clk);
        bif.start = 1'b1;
        bif.din   = d;
        bif.dir   = r;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    // Wait for done; n counts edges starting with the accepting edge.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (bif.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] d, input logic r,
                          input logic [N-1:0] e_dout, input int e_sh,
                          input logic e_zero, input int e_edges);
        int n;
        launch(d, r);
        wait_done(1, n);
        chk({tag, "_edges"}, n, e_edges);
        chk({tag, "_dout"}, bif.dout, e_dout);
        chk({tag, "_sh"}, bif.sh_amt, e_sh);
        chk({tag, "_zero"}, bif.zero, e_zero);
        @(negedge clk);
        chk({tag, "_pulse"}, bif.done, 0);
    endtask

    initial begin
        int n;
        int ndone;
        logic [N-1:0] back;

        rst       = 1'b1;
        bif.start = 1'b0;
        bif.din   = '0;
        bif.dir   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_dout", bif.dout, 0);
        chk("rst_sh",   bif.sh_amt, 0);
        chk("rst_zero", bif.zero, 0);

        // 1: already normalized, busy high for exactly one cycle
        launch(8'b1011_0011, 1'b0);
        chk("t1_busy", bif.busy, 1);
        wait_done(1, n);
        chk("t1_edges", n, 2);
        chk("t1_busy_lo", bif.busy, 0);
        chk("t1_dout", bif.dout, 8'b1011_0011);
        chk("t1_sh", bif.sh_amt, 0);
        chk("t1_zero", bif.zero, 0);
        @(negedge clk);
        chk("t1_pulse", bif.done, 0);

        // 2: left normalize, then shift back right by sh_amt
        run_op("t2", 8'b0001_0110, 1'b0, 8'b1011_0000, 3, 1'b0, 5);
        back = bif.dout >> bif.sh_amt;
        chk("t2_back", back, 8'b0001_0110);

        // 3: right normalize
        run_op("t3", 8'b1011_0000, 1'b1, 8'b0000_1011, 4, 1'b0, 6);
        run_op("t3b", 8'b1000_0000, 1'b1, 8'b0000_0001, 7, 1'b0, 9);

        // 4: zero input, then nonzero clears zero flag
        run_op("t4z", 8'h00, 1'b1, 8'h00, 0, 1'b1, 2);
        run_op("t4a", 8'h00, 1'b0, 8'h00, 0, 1'b1, 2);
        run_op("t4b", 8'b1000_0000, 1'b0, 8'b1000_0000, 0, 1'b0, 2);

        // 5: worst case with an ignored start while busy
        launch(8'b0000_0001, 1'b0);
        @(negedge clk);
        bif.start = 1'b1;
        bif.din   = 8'hFF;
        bif.dir   = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        wait_done(3, n);
        chk("t5_edges", n, 9);
        chk("t5_dout", bif.dout, 8'b1000_0000);
        chk("t5_sh", bif.sh_amt, 7);
        chk("t5_zero", bif.zero, 0);
        repeat (3) @(negedge clk);
        chk("t5_idle", bif.busy, 0);
        chk("t5_hold", bif.dout, 8'b1000_0000);

        // 6: reset mid-shift discards the operation
        launch(8'b0000_0100, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", bif.busy, 0);
        chk("t6_done", bif.done, 0);
        chk("t6_dout", bif.dout, 0);
        chk("t6_sh", bif.sh_amt, 0);
        chk("t6_zero", bif.zero, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bif.done === 1'b1) ndone++;
        end
        chk("t6_nodone", ndone, 0);
        run_op("t6b", 8'b0100_0000, 1'b0, 8'b1000_0000, 1, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
